coefficient_sink: RTL and testbench

Responder end of the coefficient-load handshake in the FIR datapath. Raises the `new_coefficient_set` request when the host writes a new set. Accepts `load_coeff`/`coefficient_num` strobes from the loader FSM and stretches `modwait` while each write commits. Holds the four filter coefficients f0..f3 for the MAC datapath and flags when a complete set is present.

---
 rtl/coefficient_sink_if.sv | 28 ++
 rtl/coefficient_sink.sv | 101 ++++++++++
 tb/tb_coefficient_sink.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/coefficient_sink_if.sv
// Coefficient-load handshake bundle between the host/loader side and the coefficient sink.
interface coefficient_sink_if #(
    parameter int unsigned DATA_W = 16
);
    logic              coeff_write;
    logic              load_coeff;
    logic [1:0]        coefficient_num;
    logic [DATA_W-1:0] coeff_data;
    logic              clear_new_coeff;
    logic              new_coefficient_set;
    logic              modwait;
    logic [DATA_W-1:0] f0;
    logic [DATA_W-1:0] f1;
    logic [DATA_W-1:0] f2;
    logic [DATA_W-1:0] f3;
    logic              coeff_ready;
    logic              err;

    modport master (
        output coeff_write, load_coeff, coefficient_num, coeff_data, clear_new_coeff,
        input  new_coefficient_set, modwait, f0, f1, f2, f3, coeff_ready, err
    );

    modport slave (
        input  coeff_write, load_coeff, coefficient_num, coeff_data, clear_new_coeff,
        output new_coefficient_set, modwait, f0, f1, f2, f3, coeff_ready, err
    );
endinterface

// File: rtl/coefficient_sink.sv
// Responder end of the coefficient-load handshake: holds f0..f3 for the MAC datapath and
// stretches modwait for WAIT_CYCLES cycles while each coefficient write commits.
module coefficient_sink #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               n_reset,
    coefficient_sink_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        pend_num_q, pend_num_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [DATA_W-1:0] f_q [4];
    logic [DATA_W-1:0] f_d [4];
    logic [3:0]        mask_q, mask_d;
    logic              req_q, req_d;
    logic              modwait_q, modwait_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_num_d  = pend_num_q;
        pend_data_d = pend_data_q;
        f_d         = f_q;
        modwait_d   = modwait_q;
        err_d       = 1'b0;

        // Set beats clear when both arrive together.
        req_d = req_q;
        if (bus.clear_new_coeff) req_d = 1'b0;
        if (bus.coeff_write)     req_d = 1'b1;

        mask_d = bus.coeff_write ? 4'b0000 : mask_q;

        unique case (state_q)
            StIdle: begin
                if (bus.load_coeff) begin
                    pend_num_d  = bus.coefficient_num;
                    pend_data_d = bus.coeff_data;
                    cnt_d       = 4'(WAIT_CYCLES);
                    modwait_d   = 1'b1;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (bus.load_coeff) err_d = 1'b1;
                if (cnt_q == 4'd1) begin
                    f_d[pend_num_q]    = pend_data_q;
                    mask_d[pend_num_q] = 1'b1;
                    modwait_d          = 1'b0;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        ready_d = &mask_d;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            pend_num_q  <= 2'd0;
            pend_data_q <= '0;
            for (int i = 0; i < 4; i++) f_q[i] <= '0;
            mask_q      <= 4'b0000;
            req_q       <= 1'b0;
            modwait_q   <= 1'b0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_num_q  <= pend_num_d;
            pend_data_q <= pend_data_d;
            f_q         <= f_d;
            mask_q      <= mask_d;
            req_q       <= req_d;
            modwait_q   <= modwait_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    assign bus.new_coefficient_set = req_q;
    assign bus.modwait             = modwait_q;
    assign bus.coeff_ready         = ready_q;
    assign bus.err                 = err_q;
    assign bus.f0                  = f_q[0];
    assign bus.f1                  = f_q[1];
    assign bus.f2                  = f_q[2];
    assign bus.f3                  = f_q[3];
endmodule

// File: tb/tb_coefficient_sink.sv
// Directed bench for coefficient_sink: a 2-cycle instance for the handshake scenarios and a
// 3-cycle instance for the latency check; committed values are matched against a scoreboard.
module tb_coefficient_sink;
    logic clk;
    logic n_reset;

    coefficient_sink_if #(.DATA_W(16)) bus2 ();
    coefficient_sink_if #(.DATA_W(16)) bus3 ();

    coefficient_sink #(.DATA_W(16), .WAIT_CYCLES(2)) dut2 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus2.slave)
    );

    coefficient_sink #(.DATA_W(16), .WAIT_CYCLES(3)) dut3 (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_f [4];
    logic [3:0]  exp_mask;
    logic        exp_req;
    int          errors;
    int          checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] f_of(input int i);
        case (i)
            0:       return bus2.f0;
            1:       return bus2.f1;
            2:       return bus2.f2;
            default: return bus2.f3;
        endcase
    endfunction

    task automatic check_all_f(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_f%0d", tag, k), 32'(f_of(k)), 32'(exp_f[k]));
    endtask

    // Called positioned just after a falling edge; leaves the bench after the next one.
    task automatic pulse(input logic wr, input logic clr);
        bus2.coeff_write     = wr;
        bus2.clear_new_coeff = clr;
        @(negedge clk);
        bus2.coeff_write     = 1'b0;
        bus2.clear_new_coeff = 1'b0;
        if (wr) begin
            exp_mask = 4'b0000;
            exp_req  = 1'b1;
        end else if (clr) begin
            exp_req = 1'b0;
        end
    endtask

    // Wait out the busy window, then retire the oldest scoreboard entry against the f registers.
    task automatic finish_load(input string tag, input int already_high);
        int   n;
        exp_t e;
        n = already_high;
        while (bus2.modwait === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_modwait_len"}, 32'(n), 32'd2);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            exp_f[e.idx]    = e.data;
            exp_mask[e.idx] = 1'b1;
        end
        check_all_f(tag);
        chk({tag, "_ready"}, 32'(bus2.coeff_ready), 32'(&exp_mask));
        chk({tag, "_req"}, 32'(bus2.new_coefficient_set), 32'(exp_req));
    endtask

    task automatic load2(input string tag, input int idx, input logic [15:0] d);
        bus2.load_coeff      = 1'b1;
        bus2.coefficient_num = 2'(idx);
        bus2.coeff_data      = d;
        sb.push_back('{idx, d});
        @(negedge clk);
        bus2.load_coeff = 1'b0;
        bus2.coeff_data = 16'h0;
        finish_load(tag, 0);
        chk({tag, "_err"}, 32'(bus2.err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors   = 0;
        checks   = 0;
        exp_mask = 4'b0000;
        exp_req  = 1'b0;
        for (int k = 0; k < 4; k++) exp_f[k] = 16'h0;
        n_reset  = 1'b0;
        bus2.coeff_write = 1'b0; bus2.load_coeff = 1'b0; bus2.coefficient_num = 2'd0;
        bus2.coeff_data  = 16'h0; bus2.clear_new_coeff = 1'b0;
        bus3.coeff_write = 1'b0; bus3.load_coeff = 1'b0; bus3.coefficient_num = 2'd0;
        bus3.coeff_data  = 16'h0; bus3.clear_new_coeff = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_modwait", 32'(bus2.modwait), 32'd0);
        chk("rst_req", 32'(bus2.new_coefficient_set), 32'd0);
        chk("rst_ready", 32'(bus2.coeff_ready), 32'd0);
        chk("rst_err", 32'(bus2.err), 32'd0);
        check_all_f("rst");
        n_reset = 1'b1;
        @(negedge clk);

        // Latency on the 3-cycle instance.
        bus3.load_coeff = 1'b1; bus3.coefficient_num = 2'd2; bus3.coeff_data = 16'hBEEF;
        @(negedge clk);
        bus3.load_coeff = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("lat_modwait_c%0d", c), 32'(bus3.modwait), 32'd1);
            chk($sformatf("lat_f2_c%0d", c), 32'(bus3.f2), 32'd0);
            @(negedge clk);
        end
        chk("lat_modwait_low", 32'(bus3.modwait), 32'd0);
        chk("lat_f2", 32'(bus3.f2), 32'hBEEF);
        chk("lat_f0", 32'(bus3.f0), 32'd0);
        chk("lat_f1", 32'(bus3.f1), 32'd0);
        chk("lat_f3", 32'(bus3.f3), 32'd0);

        // Full handshake.
        pulse(1'b1, 1'b0);
        chk("hs_req_set", 32'(bus2.new_coefficient_set), 32'd1);
        load2("hs0", 0, 16'h0001);
        load2("hs1", 1, 16'h0002);
        load2("hs2", 2, 16'h0003);
        load2("hs3", 3, 16'h0004);
        pulse(1'b0, 1'b1);
        chk("hs_req_clr", 32'(bus2.new_coefficient_set), 32'd0);
        chk("hs_ready_hold", 32'(bus2.coeff_ready), 32'd1);

        // Load issued while busy is rejected; the first write still completes on time.
        bus2.load_coeff = 1'b1; bus2.coefficient_num = 2'd0; bus2.coeff_data = 16'hAAAA;
        sb.push_back('{0, 16'hAAAA});
        @(negedge clk);
        chk("viol_busy", 32'(bus2.modwait), 32'd1);
        bus2.coefficient_num = 2'd1; bus2.coeff_data = 16'h1111;
        @(negedge clk);
        bus2.load_coeff = 1'b0;
        chk("viol_err", 32'(bus2.err), 32'd1);
        finish_load("viol", 1);
        chk("viol_err_1cyc", 32'(bus2.err), 32'd0);

        // Simultaneous write and clear: set wins and the mask restarts.
        pulse(1'b1, 1'b1);
        chk("sim_req", 32'(bus2.new_coefficient_set), 32'd1);
        chk("sim_ready", 32'(bus2.coeff_ready), 32'd0);
        load2("sim0", 0, 16'h0100);
        load2("sim1", 1, 16'h0101);
        load2("sim2", 2, 16'h0102);
        load2("sim3", 3, 16'h0103);

        // Reset in the middle of a busy window.
        bus2.load_coeff = 1'b1; bus2.coefficient_num = 2'd0; bus2.coeff_data = 16'h5555;
        @(negedge clk);
        bus2.load_coeff = 1'b0;
        chk("mid_busy", 32'(bus2.modwait), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("mid_modwait", 32'(bus2.modwait), 32'd0);
        chk("mid_req", 32'(bus2.new_coefficient_set), 32'd0);
        chk("mid_ready", 32'(bus2.coeff_ready), 32'd0);
        sb.delete();
        for (int k = 0; k < 4; k++) exp_f[k] = 16'h0;
        exp_mask = 4'b0000;
        exp_req  = 1'b0;
        check_all_f("mid");
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        load2("post_rst", 1, 16'h7777);

        // Out-of-order loads with a reload of index 1.
        pulse(1'b1, 1'b0);
        load2("ooo3", 3, 16'h3003);
        load2("ooo1a", 1, 16'h1001);
        load2("ooo1b", 1, 16'h1002);
        load2("ooo0", 0, 16'h0009);
        chk("ooo_ready_before", 32'(bus2.coeff_ready), 32'd0);
        load2("ooo2", 2, 16'h2002);
        chk("ooo_f1_second", 32'(bus2.f1), 32'h1002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
